// File: rtl/pri_encoder32_5.sv
// pri_encoder32_5
//   Sticky 32-input priority encoder with a valid/ack handshake.
//   Active-low requests on L are captured into a pending register whenever
//   the active-low enable E is low. The highest pending index is presented
//   on B with valid=1. It stays there until the consumer acks, which retires
//   that bit.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous, active-high reset
//   E         in   1   active-low capture enable (0 = sample L)
//   L         in  32   active-low request lines (L[i]=0 requests index i)
//   ack       in   1   consumer accepts B (ignored while valid=0)
//   B         out  5   presented request index
//   valid     out  1   B holds a request awaiting ack
//   empty     out  1   nothing pending and nothing presented
//   pend_cnt  out  6   popcount of the pending register

module pri_encoder32_5 (
  input  logic        clk,
  input  logic        rst,
  input  logic        E,
  input  logic [31:0] L,
  input  logic        ack,
  output logic [4:0]  B,
  output logic        valid,
  output logic        empty,
  output logic [5:0]  pend_cnt
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t      state;
  logic [31:0] pend;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pend_next;
  logic [4:0]  top_idx;
  logic [5:0]  next_cnt;

  // New requests for this edge: only sampled while the enable is low.
  always_comb begin
    set_mask = '0;
    if (!E) begin
      set_mask = ~L;
    end
  end

  // The presented bit retires only on an ack while something is presented.
  always_comb begin
    clr_mask = '0;
    if ((state == PRESENT) && ack) begin
      clr_mask = 32'd1 << B;
    end
  end

  // Clear first, then set, so a re-request of the acked index survives.
  always_comb begin
    pend_next = (pend & ~clr_mask) | set_mask;
  end

  // Highest set index of the registered pend. Ascending scan: the last hit wins.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (pend[i]) begin
        top_idx = 5'(i);
      end
    end
  end

  // Popcount of the next pend value. pend_cnt then changes on the same edge as pend.
  always_comb begin
    next_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      next_cnt = next_cnt + {5'd0, pend_next[i]};
    end
  end

  // Pending register, count and presentation FSM.
  // A new code is chosen only in IDLE. A higher-priority arrival therefore
  // never disturbs the presented code. At least one idle cycle also
  // separates consecutive codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
      B        <= '0;
      valid    <= 1'b0;
      state    <= IDLE;
    end else begin
      pend     <= pend_next;
      pend_cnt <= next_cnt;
      case (state)
        IDLE: begin
          if (|pend) begin
            B     <= top_idx;
            valid <= 1'b1;
            state <= PRESENT;
          end else begin
            valid <= 1'b0;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Derived purely from registered state.
  assign empty = (pend == '0) && !valid;

endmodule

// File: tb/tb_pri_encoder32_5.sv
// tb_pri_encoder32_5
//   Directed testbench for pri_encoder32_5. Each scenario task drives inputs
//   #1 after a rising edge and checks outputs at that same point.

module tb_pri_encoder32_5;

  logic        clk;
  logic        rst;
  logic        E;
  logic [31:0] L;
  logic        ack;
  logic [4:0]  B;
  logic        valid;
  logic        empty;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  pri_encoder32_5 dut (
    .clk      (clk),
    .rst      (rst),
    .E        (E),
    .L        (L),
    .ack      (ack),
    .B        (B),
    .valid    (valid),
    .empty    (empty),
    .pend_cnt (pend_cnt)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    E   = 1'b1;
    L   = '1;
    ack = 1'b0;
  endtask

  task automatic pulse_reset();
    quiet_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reset must win over a full request and an ack on the same edge.
  task automatic test_reset();
    rst = 1'b1; E = 1'b0; L = '0; ack = 1'b1;
    tick();
    checks++; if (valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid got %0d expected 0", valid); end
    checks++; if (B !== 5'd0)      begin errors++; $display("[TB] FAIL reset_B got %0d expected 0", B); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d expected 0", pend_cnt); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("[TB] FAIL reset_empty got %0d expected 1", empty); end
    rst = 1'b0;
    quiet_inputs();
    tick();
    checks++; if (empty !== 1'b1)  begin errors++; $display("[TB] FAIL reset_hold_empty got %0d expected 1", empty); end
  endtask

  task automatic test_single();
    pulse_reset();
    E = 1'b0; L = ~(32'd1 << 5);
    tick();
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("[TB] FAIL single_cnt got %0d expected 1", pend_cnt); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("[TB] FAIL single_early_valid got %0d expected 0", valid); end
    checks++; if (empty !== 1'b0)  begin errors++; $display("[TB] FAIL single_empty got %0d expected 0", empty); end
    quiet_inputs();
    tick();
    checks++; if (valid !== 1'b1)  begin errors++; $display("[TB] FAIL single_valid got %0d expected 1", valid); end
    checks++; if (B !== 5'd5)      begin errors++; $display("[TB] FAIL single_B got %0d expected 5", B); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (valid !== 1'b0)  begin errors++; $display("[TB] FAIL single_ack_valid got %0d expected 0", valid); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("[TB] FAIL single_ack_empty got %0d expected 1", empty); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("[TB] FAIL single_ack_cnt got %0d expected 0", pend_cnt); end
  endtask

  // Codes 30, 17, 3 in order with one idle cycle between them. ack is held
  // high throughout, so it is also ignored while idle.
  task automatic test_priority();
    logic [4:0] codes [3] = '{5'd30, 5'd17, 5'd3};
    pulse_reset();
    E = 1'b0; L = ~((32'd1 << 3) | (32'd1 << 17) | (32'd1 << 30));
    tick();
    checks++; if (pend_cnt !== 6'd3) begin errors++; $display("[TB] FAIL prio_cnt0 got %0d expected 3", pend_cnt); end
    E = 1'b1; L = '1; ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL prio_valid[%0d] got %0d expected 1", j, valid); end
      checks++; if (B !== codes[j]) begin errors++; $display("[TB] FAIL prio_B[%0d] got %0d expected %0d", j, B, codes[j]); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_gap[%0d] got %0d expected 0", j, valid); end
      checks++; if (pend_cnt !== 6'(2 - j)) begin errors++; $display("[TB] FAIL prio_cnt[%0d] got %0d expected %0d", j, pend_cnt, 2 - j); end
    end
    ack = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL prio_empty got %0d expected 1", empty); end
  endtask

  task automatic test_no_preempt();
    pulse_reset();
    E = 1'b0; L = ~(32'd1 << 4);
    tick();
    quiet_inputs();
    tick();
    checks++; if (B !== 5'd4) begin errors++; $display("[TB] FAIL nopre_B got %0d expected 4", B); end
    E = 1'b0; L = ~(32'd1 << 31);
    tick();
    quiet_inputs();
    checks++; if (pend_cnt !== 6'd2) begin errors++; $display("[TB] FAIL nopre_cnt got %0d expected 2", pend_cnt); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (B !== 5'd4 || valid !== 1'b1) begin errors++; $display("[TB] FAIL nopre_hold[%0d] got B=%0d v=%0d expected B=4 v=1", j, B, valid); end
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (valid !== 1'b0 || pend_cnt !== 6'd1) begin errors++; $display("[TB] FAIL nopre_ack got v=%0d cnt=%0d expected v=0 cnt=1", valid, pend_cnt); end
    tick();
    checks++; if (B !== 5'd31 || valid !== 1'b1) begin errors++; $display("[TB] FAIL nopre_next got B=%0d v=%0d expected B=31 v=1", B, valid); end
  endtask

  task automatic test_enable_gating();
    pulse_reset();
    E = 1'b1; L = '0; ack = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++; if (empty !== 1'b1 || pend_cnt !== 6'd0) begin errors++; $display("[TB] FAIL gate_idle[%0d] got empty=%0d cnt=%0d expected 1/0", j, empty, pend_cnt); end
    end
    ack = 1'b0; E = 1'b0;
    tick();
    checks++; if (pend_cnt !== 6'd32) begin errors++; $display("[TB] FAIL gate_cnt got %0d expected 32", pend_cnt); end
    quiet_inputs();
    tick();
    checks++; if (B !== 5'd31 || valid !== 1'b1) begin errors++; $display("[TB] FAIL gate_first got B=%0d v=%0d expected B=31 v=1", B, valid); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (pend_cnt !== 6'd31) begin errors++; $display("[TB] FAIL gate_ack_cnt got %0d expected 31", pend_cnt); end
  endtask

  task automatic test_set_wins();
    pulse_reset();
    E = 1'b0; L = ~(32'd1 << 9);
    tick();
    tick();
    checks++; if (B !== 5'd9 || valid !== 1'b1) begin errors++; $display("[TB] FAIL setwin_first got B=%0d v=%0d expected B=9 v=1", B, valid); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (valid !== 1'b0 || pend_cnt !== 6'd1) begin errors++; $display("[TB] FAIL setwin_keep got v=%0d cnt=%0d expected v=0 cnt=1", valid, pend_cnt); end
    tick();
    checks++; if (B !== 5'd9 || valid !== 1'b1) begin errors++; $display("[TB] FAIL setwin_again got B=%0d v=%0d expected B=9 v=1", B, valid); end
    quiet_inputs();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL setwin_empty got %0d expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    E = 1'b0; L = ~((32'd1 << 12) | (32'd1 << 5) | (32'd1 << 2));
    tick();
    quiet_inputs();
    tick();
    checks++; if (B !== 5'd12 || valid !== 1'b1 || pend_cnt !== 6'd3) begin errors++; $display("[TB] FAIL mid_setup got B=%0d v=%0d cnt=%0d expected 12/1/3", B, valid, pend_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (valid !== 1'b0 || B !== 5'd0) begin errors++; $display("[TB] FAIL mid_rst got B=%0d v=%0d expected 0/0", B, valid); end
    checks++; if (pend_cnt !== 6'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_pend got cnt=%0d empty=%0d expected 0/1", pend_cnt, empty); end
    tick();
    tick();
    checks++; if (valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_survive got v=%0d empty=%0d expected 0/1", valid, empty); end
  endtask

  initial begin
    rst = 1'b0;
    quiet_inputs();
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_enable_gating();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
